memory_burst_rtl: RTL and testbench

//  Parametrised successor to the single-beat memory: register-array RAM with
//  a valid/ready command handshake, multi-beat write/read bursts and

---
 rtl/memory_burst_rtl.sv | 138 +++++++++++++
 tb/tb_memory_burst_rtl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_burst_rtl.sv
// ============================================================================
// memory_burst_rtl : register-array RAM with a valid/ready command handshake,
//                    multi-beat bursts and a bounds-checked error pulse.
// Rev 1.0
// ============================================================================
`default_nettype none

module memory_burst_rtl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int DEPTH     = 16,
   parameter int MAX_BURST = 4,
   localparam int LEN_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              activate_i,
   input  logic              valid_i,
   input  logic              wr_rd_enb_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LEN_W-1:0]  burst_len_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] data_out_o,
   output logic              rd_valid_o,
   output logic              error_o,
   output logic              busy_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [LEN_W-1:0]  cnt_q,      cnt_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              accept;
   logic              in_range;
   logic [31:0]       last_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;

   // ready is forced low while reset is held so every output reads 0 then.
   assign ready_o    = rst_n & activate_i & ((state_q == S_IDLE) | (state_q == S_WR));
   assign busy_o     = (state_q != S_IDLE);
   assign error_o    = (state_q == S_ERR);
   assign data_out_o = data_out_q;
   assign rd_valid_o = rd_valid_q;

   assign accept    = ready_o & valid_i & (state_q == S_IDLE);
   assign last_addr = 32'(addr_i) + 32'(burst_len_i);
   assign in_range  = (last_addr <= 32'(DEPTH - 1));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      wr_en      = 1'b0;
      wr_addr    = addr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!in_range) begin
                  state_d = S_ERR;
               end else begin
                  addr_d = addr_i + ADDR_W'(1);
                  cnt_d  = burst_len_i;
                  if (wr_rd_enb_i) begin
                     wr_en   = 1'b1;
                     wr_addr = addr_i;
                     if (burst_len_i != '0) state_d = S_WR;
                  end else begin
                     data_out_d = mem_q[addr_i];
                     rd_valid_d = 1'b1;
                     state_d    = S_RD;
                  end
               end
            end
         end
         S_WR: begin
            // cnt_q counts the beats still owed after beat 0.
            if (!activate_i) begin
               state_d = S_IDLE;
            end else if (valid_i) begin
               wr_en  = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               cnt_d  = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (!activate_i || (cnt_q == '0)) begin
               state_d = S_IDLE;
            end else begin
               data_out_d = mem_q[addr_q];
               rd_valid_d = 1'b1;
               addr_d     = addr_q + ADDR_W'(1);
               cnt_d      = cnt_q - LEN_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= data_in_i;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memory_burst_rtl.sv
// ============================================================================
// tb_memory_burst_rtl : directed and randomized bursts against an array model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_burst_rtl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       activate;
   logic       valid;
   logic       wr_rd_enb;
   logic [3:0] addr;
   logic [1:0] burst_len;
   logic [7:0] data_in;
   logic       ready;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       error;
   logic       busy;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] model_mem [16];

   memory_burst_rtl #(
      .DATA_W(8), .ADDR_W(4), .DEPTH(16), .MAX_BURST(4)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .activate_i (activate),
      .valid_i    (valid),
      .wr_rd_enb_i(wr_rd_enb),
      .addr_i     (addr),
      .burst_len_i(burst_len),
      .data_in_i  (data_in),
      .ready_o    (ready),
      .data_out_o (data_out),
      .rd_valid_o (rd_valid),
      .error_o    (error),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // abort_at: beat index whose cycle is replaced by dropping activate (-1 = none)
   task automatic do_write(input int a, input int len, input logic [31:0] dpk,
                           input bit gaps, input int abort_at);
      logic [31:0] d;
      d         = dpk;
      activate  = 1'b1;
      valid     = 1'b1;
      wr_rd_enb = 1'b1;
      addr      = 4'(a);
      burst_len = 2'(len);
      data_in   = d[7:0];
      #1;
      check("wr_ready", ready, 1);
      cycle();
      valid = 1'b0;
      if (a + len > 15) begin
         check("err_pulse", error, 1);
         check("err_busy", busy, 1);
         cycle();
         check("err_clear", error, 0);
         check("err_idle", busy, 0);
         return;
      end
      model_mem[a] = d[7:0];
      for (int k = 1; k <= len; k++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               data_in = 8'($urandom);
               cycle();
               check("wr_stall_busy", busy, 1);
            end
         end
         if (k == abort_at) begin
            activate = 1'b0;
            cycle();
            check("wr_abort_idle", busy, 0);
            activate = 1'b1;
            return;
         end
         valid   = 1'b1;
         data_in = d[8*k +: 8];
         cycle();
         valid = 1'b0;
         model_mem[a+k] = d[8*k +: 8];
      end
      check("wr_done_idle", busy, 0);
   endtask

   // abort_at: drop activate during the cycle showing this beat (-1 = none)
   task automatic do_read(input int a, input int len, input int abort_at);
      activate  = 1'b1;
      valid     = 1'b1;
      wr_rd_enb = 1'b0;
      addr      = 4'(a);
      burst_len = 2'(len);
      #1;
      check("rd_ready", ready, 1);
      cycle();
      valid = 1'b0;
      if (a + len > 15) begin
         check("err_pulse", error, 1);
         check("err_rd_valid", rd_valid, 0);
         cycle();
         check("err_clear", error, 0);
         check("err_idle", busy, 0);
         return;
      end
      for (int k = 0; k <= len; k++) begin
         valid     = 1'($urandom_range(0, 1));
         wr_rd_enb = 1'($urandom_range(0, 1));
         check("rd_valid", rd_valid, 1);
         check("rd_data", data_out, model_mem[a+k]);
         check("rd_ready_low", ready, 0);
         if (k == abort_at) begin
            activate = 1'b0;
            cycle();
            valid = 1'b0;
            check("rd_abort_valid", rd_valid, 0);
            check("rd_abort_idle", busy, 0);
            activate = 1'b1;
            return;
         end
         cycle();
      end
      valid = 1'b0;
      check("rd_end_valid", rd_valid, 0);
      check("rd_end_idle", busy, 0);
      check("rd_hold", data_out, model_mem[a+len]);
   endtask

   task automatic dump_all();
      for (int i = 0; i < 16; i++) do_read(i, 0, -1);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a, len, op, ab;
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      rst_n     = 1'b0;
      activate  = 1'b1;
      valid     = 1'b0;
      wr_rd_enb = 1'b0;
      addr      = '0;
      burst_len = '0;
      data_in   = '0;
      #12;
      check("rst_ready", ready, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_data_out", data_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // single write then read
      do_write(3, 0, 32'h000000A5, 1'b0, -1);
      do_read(3, 0, -1);
      // burst with valid gaps
      do_write(4, 3, 32'h44332211, 1'b1, -1);
      do_read(4, 3, -1);
      // out-of-range burst leaves memory untouched
      do_write(14, 3, 32'hDEADBEEF, 1'b0, -1);
      do_read(14, 1, -1);
      do_read(13, 3, -1);
      // read immediately after write to the same address
      do_write(7, 0, 32'h0000005A, 1'b0, -1);
      do_read(7, 0, -1);
      // abort a read after beat 1, then a fresh command
      do_read(0, 3, 1);
      do_read(4, 1, -1);
      // abort a write before beat 2
      do_write(8, 3, 32'hC3B2A190, 1'b0, 2);
      do_read(8, 3, -1);

      activate = 1'b0;
      valid    = 1'b1;
      #1;
      check("inactive_ready", ready, 0);
      cycle();
      check("inactive_idle", busy, 0);
      valid = 1'b0;

      for (int it = 0; it < 80; it++) begin
         a   = int'($urandom_range(0, 15));
         len = int'($urandom_range(0, 3));
         op  = int'($urandom_range(0, 2));
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
         if (op == 0) do_read(a, len, ab);
         else         do_write(a, len, $urandom, 1'b1, (ab == 0) ? -1 : ab);
      end
      dump_all();

      // reset in the middle of a write burst
      do_read(4, 0, -1);
      activate  = 1'b1;
      valid     = 1'b1;
      wr_rd_enb = 1'b1;
      addr      = 4'd2;
      burst_len = 2'd3;
      data_in   = 8'h77;
      cycle();
      data_in = 8'h88;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ready", ready, 0);
      check("arst_busy", busy, 0);
      check("arst_error", error, 0);
      check("arst_rd_valid", rd_valid, 0);
      check("arst_data_out", data_out, 0);
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      activate = 1'b0;
      valid    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      dump_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
